// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with byte storage for the core's load path.
//
// A 2-flop synchronizer feeds a start/data/stop FSM that samples each bit mid-period.
// Completed bytes go into storage. The storage is a FIFO_DEPTH-entry circular FIFO
// when UART_RX_FIFO_EN is defined, and a single holding register otherwise.
//
// Parameters:
//   CLKS_PER_BIT - clk cycles per bit period (>= 4)
//   FIFO_DEPTH   - FIFO entries (power of two, >= 2); used only with UART_RX_FIFO_EN
//
// Ports:
//   clk       - core clock, rising edge
//   rst       - synchronous active-high reset
//   rx        - asynchronous serial line, idle high
//   rx_read   - one-cycle pop request; also clears the sticky flags
//   rx_data   - head byte, 8'h00 when nothing is held
//   rx_ready  - at least one byte is held
//   frame_err - sticky: a stop bit was sampled low
//   overrun   - sticky: a byte was dropped because storage was full
//
// Build option: define UART_RX_FIFO_EN to select FIFO storage.

module uart_rx #(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    input  logic       rx_read,
    output logic [7:0] rx_data,
    output logic       rx_ready,
    output logic       frame_err,
    output logic       overrun
);

    localparam int unsigned CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HalfSample = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FullSample = CW'(CLKS_PER_BIT - 1);

    if (CLKS_PER_BIT < 4) begin : g_bad_clks_per_bit
        $error("uart_rx: CLKS_PER_BIT must be >= 4");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_fifo_depth
        $error("uart_rx: FIFO_DEPTH must be a power of two >= 2");
    end

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    logic          rx_meta_q, rx_s_q;
    state_e        state_q, state_d;
    logic [CW-1:0] clk_cnt_q, clk_cnt_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          wait_high_q, wait_high_d;
    logic          frame_err_q, frame_err_d;
    logic          overrun_q, overrun_d;
    logic          push, frame_set, overrun_set;

    // ---------------------------------------------------------------- receive FSM
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_q   <= 1'b1;
            rx_s_q      <= 1'b1;
            state_q     <= StIdle;
            clk_cnt_q   <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            wait_high_q <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            rx_meta_q   <= rx;
            rx_s_q      <= rx_meta_q;
            state_q     <= state_d;
            clk_cnt_q   <= clk_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            wait_high_q <= wait_high_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        clk_cnt_d   = clk_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        wait_high_d = wait_high_q;
        push        = 1'b0;
        frame_set   = 1'b0;
        unique case (state_q)
            StIdle: begin
                clk_cnt_d = '0;
                bit_cnt_d = '0;
                // After a framing error the line may still be low; only a return to
                // high re-arms start detection.
                if (rx_s_q) begin
                    wait_high_d = 1'b0;
                end else if (!wait_high_q) begin
                    state_d = StStart;
                end
            end
            StStart: begin
                if (clk_cnt_q == HalfSample) begin
                    clk_cnt_d = '0;
                    state_d   = rx_s_q ? StIdle : StData;
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end
            StData: begin
                if (clk_cnt_q == FullSample) begin
                    clk_cnt_d = '0;
                    shift_d   = {rx_s_q, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = StStop;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end
            StStop: begin
                if (clk_cnt_q == FullSample) begin
                    clk_cnt_d = '0;
                    state_d   = StIdle;
                    if (rx_s_q) begin
                        push = 1'b1;
                    end else begin
                        frame_set   = 1'b1;
                        wait_high_d = 1'b1;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Set wins over a clear from rx_read in the same cycle.
    always_comb begin
        frame_err_d = frame_set | (frame_err_q & ~rx_read);
        overrun_d   = overrun_set | (overrun_q & ~rx_read);
    end

    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

    // ---------------------------------------------------------------- storage
`ifdef UART_RX_FIFO_EN
    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam logic [PW:0] DepthCount = (PW + 1)'(FIFO_DEPTH);

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PW:0]   count_q, count_d;
    logic          pop, full, accept;

    always_comb begin
        pop         = rx_read && (count_q != '0);
        full        = (count_q == DepthCount);
        // Pop is applied first, so a full FIFO popped this cycle has room.
        accept      = push && (!full || pop);
        overrun_set = push && full && !pop;
        rd_ptr_d    = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        wr_ptr_d    = accept ? wr_ptr_q + 1'b1 : wr_ptr_q;
        count_d     = count_q;
        unique case ({accept, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry contents need no reset; count gates visibility.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem_q[wr_ptr_q] <= shift_q;
        end
    end

    always_comb begin
        rx_ready = (count_q != '0);
        rx_data  = rx_ready ? mem_q[rd_ptr_q] : 8'h00;
    end
`else
    logic [7:0] hold_q, hold_d;
    logic       valid_q, valid_d;
    logic       pop, accept;

    always_comb begin
        pop         = rx_read && valid_q;
        accept      = push && (!valid_q || pop);
        overrun_set = push && valid_q && !pop;
        hold_d      = accept ? shift_q : hold_q;
        valid_d     = accept ? 1'b1 : (pop ? 1'b0 : valid_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            hold_q  <= hold_d;
            valid_q <= valid_d;
        end
    end

    always_comb begin
        rx_ready = valid_q;
        rx_data  = valid_q ? hold_q : 8'h00;
    end
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Directed self-checking bench for uart_rx at CLKS_PER_BIT = 16.
// Expectations follow UART_RX_FIFO_EN: four-entry FIFO when defined, single register otherwise.

module tb_uart_rx;

    localparam int unsigned Cpb = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx = 1'b1;
    logic       rx_read = 1'b0;
    logic [7:0] rx_data;
    logic       rx_ready;
    logic       frame_err;
    logic       overrun;

    int n_checks = 0;
    int n_pass   = 0;

    uart_rx #(
        .CLKS_PER_BIT(Cpb),
        .FIFO_DEPTH  (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rx       (rx),
        .rx_read  (rx_read),
        .rx_data  (rx_data),
        .rx_ready (rx_ready),
        .frame_err(frame_err),
        .overrun  (overrun)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
        end
    endtask

    // Start bit plus eight data bits, LSB first; leaves rx on the last data bit.
    task automatic send_bits(input logic [7:0] b);
        rx = 1'b0;
        repeat (Cpb) tick();
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (Cpb) tick();
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        send_bits(b);
        rx = stop;
        repeat (Cpb) tick();
    endtask

    task automatic read_pulse();
        rx_read = 1'b1;
        tick();
        rx_read = 1'b0;
    endtask

    initial begin
        logic [7:0] exp_q [$];

        // Reset
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        chk("reset_ready", {7'd0, rx_ready}, 8'h00);
        chk("reset_data", rx_data, 8'h00);
        chk("reset_frame_err", {7'd0, frame_err}, 8'h00);
        chk("reset_overrun", {7'd0, overrun}, 8'h00);
        repeat (4) tick();

        // Single frame with exact latency: stop sample lands 155 edges after the start edge
        send_bits(8'h55);
        rx = 1'b1;
        repeat (10) tick();
        chk("single_ready_early", {7'd0, rx_ready}, 8'h00);
        tick();
        chk("single_ready", {7'd0, rx_ready}, 8'h01);
        chk("single_data", rx_data, 8'h55);
        repeat (5) tick();
        read_pulse();
        chk("single_pop_ready", {7'd0, rx_ready}, 8'h00);
        chk("single_pop_data", rx_data, 8'h00);

        // Glitch: short low pulse is rejected
        rx = 1'b0;
        repeat (4) tick();
        rx = 1'b1;
        repeat (3 * Cpb) tick();
        chk("glitch_ready", {7'd0, rx_ready}, 8'h00);
        chk("glitch_frame_err", {7'd0, frame_err}, 8'h00);
        send_frame(8'hA3, 1'b1);
        chk("after_glitch_ready", {7'd0, rx_ready}, 8'h01);
        chk("after_glitch_data", rx_data, 8'hA3);
        read_pulse();

        // Framing error
        send_frame(8'h3C, 1'b0);
        chk("ferr_flag", {7'd0, frame_err}, 8'h01);
        chk("ferr_ready", {7'd0, rx_ready}, 8'h00);
        repeat (3 * Cpb) tick();
        chk("ferr_no_restart", {7'd0, rx_ready}, 8'h00);
        rx = 1'b1;
        repeat (4) tick();
        send_frame(8'h81, 1'b1);
        chk("ferr_next_ready", {7'd0, rx_ready}, 8'h01);
        chk("ferr_next_data", rx_data, 8'h81);
        chk("ferr_sticky", {7'd0, frame_err}, 8'h01);
        read_pulse();
        chk("ferr_cleared", {7'd0, frame_err}, 8'h00);
        chk("ferr_drained", {7'd0, rx_ready}, 8'h00);

        // Back-to-back 0x01..0x05, no reads
        for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1);
        chk("b2b_overrun", {7'd0, overrun}, 8'h01);
`ifdef UART_RX_FIFO_EN
        exp_q = '{8'h01, 8'h02, 8'h03, 8'h04};
`else
        exp_q = '{8'h01};
`endif
        foreach (exp_q[i]) begin
            chk("b2b_ready", {7'd0, rx_ready}, 8'h01);
            chk("b2b_data", rx_data, exp_q[i]);
            read_pulse();
            chk("b2b_overrun_clr", {7'd0, overrun}, 8'h00);
        end
        chk("b2b_empty_ready", {7'd0, rx_ready}, 8'h00);
        chk("b2b_empty_data", rx_data, 8'h00);

        // Fill storage, then pop on the exact push cycle of 0x77
`ifdef UART_RX_FIFO_EN
        for (int i = 0; i < 4; i++) send_frame(8'h10 + 8'(i), 1'b1);
        exp_q = '{8'h11, 8'h12, 8'h13, 8'h77};
`else
        send_frame(8'h10, 1'b1);
        exp_q = '{8'h77};
`endif
        chk("simul_full_ovr", {7'd0, overrun}, 8'h00);
        send_bits(8'h77);
        rx = 1'b1;
        repeat (10) tick();
        rx_read = 1'b1;
        tick();
        rx_read = 1'b0;
        chk("simul_overrun", {7'd0, overrun}, 8'h00);
        repeat (5) tick();
        foreach (exp_q[i]) begin
            chk("simul_data", rx_data, exp_q[i]);
            read_pulse();
        end
        chk("simul_empty", {7'd0, rx_ready}, 8'h00);

        // Reset mid-frame with a byte held and a framing error pending
        send_frame(8'h99, 1'b1);
        send_frame(8'h5A, 1'b0);
        rx = 1'b1;
        repeat (4) tick();
        chk("pre_rst_ready", {7'd0, rx_ready}, 8'h01);
        chk("pre_rst_ferr", {7'd0, frame_err}, 8'h01);
        rx = 1'b0;
        repeat (Cpb) tick();
        rx = 1'b0;  // bits 0..2 of 0xF0 are all 0
        repeat (3 * Cpb + Cpb / 2) tick();
        rst = 1'b1;
        rx  = 1'b1;
        repeat (2) tick();
        chk("rst_mid_ready", {7'd0, rx_ready}, 8'h00);
        chk("rst_mid_data", rx_data, 8'h00);
        chk("rst_mid_ferr", {7'd0, frame_err}, 8'h00);
        chk("rst_mid_ovr", {7'd0, overrun}, 8'h00);
        rst = 1'b0;
        repeat (2 * Cpb) tick();
        chk("rst_idle_ready", {7'd0, rx_ready}, 8'h00);
        send_frame(8'h12, 1'b1);
        chk("rst_next_ready", {7'd0, rx_ready}, 8'h01);
        chk("rst_next_data", rx_data, 8'h12);
        read_pulse();
        chk("rst_next_empty", {7'd0, rx_ready}, 8'h00);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
